// File: rtl/ps2_keycode_rx.sv
// PS/2 Set-2 keyboard receiver: conditions pins, deserialises frames, maps game keys to HID codes (build option PS2_RX_PARITY_CHECK_EN).
// Latency: byte_strobe/rx_byte one Clk after the filtered stop-bit sample, keycode/key_event one Clk after byte_strobe.
// Backpressure: none; the keyboard cannot be stalled, so every accepted byte is decoded immediately.
module ps2_keycode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_event,
    output logic       byte_strobe,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          samp_bit;

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          par_bit, par_nxt;
    logic [TW-1:0] to_cnt;
    logic          par_ok;
    logic          accept;
    logic          err;

    logic          ext_flag;
    logic          brk_flag;
    logic [7:0]    hid;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Glitch filter; the data bit is captured together with the filtered falling edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
            samp_bit <= 1'b1;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= filt_clk;
                samp_bit <= dat_sync[1];
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

`ifdef PS2_RX_PARITY_CHECK_EN
    assign par_ok = ^{shift, par_bit};
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        par_nxt     = par_bit;
        accept      = 1'b0;
        err         = 1'b0;
        if (state != S_IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            err       = 1'b1;
            state_nxt = S_IDLE;
        end else if (fall) begin
            case (state)
                S_IDLE: begin
                    if (!samp_bit) begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_nxt   = {samp_bit, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_nxt   = samp_bit;
                    state_nxt = S_STOP;
                end
                S_STOP: begin
                    state_nxt = S_IDLE;
                    if (samp_bit && par_ok) begin
                        accept = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            bit_cnt     <= 3'd0;
            shift       <= 8'h00;
            par_bit     <= 1'b0;
            to_cnt      <= '0;
            byte_strobe <= 1'b0;
            rx_byte     <= 8'h00;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift       <= shift_nxt;
            par_bit     <= par_nxt;
            to_cnt      <= (fall || state == S_IDLE) ? '0 : to_cnt + TW'(1);
            byte_strobe <= accept;
            frame_err   <= err;
            if (accept) begin
                rx_byte <= shift;
            end
        end
    end

    function automatic logic [7:0] hid_lookup(input logic ext, input logic [7:0] code);
        case ({ext, code})
            9'h01C:  return 8'h04;
            9'h023:  return 8'h07;
            9'h01D:  return 8'h1A;
            9'h01B:  return 8'h16;
            9'h174:  return 8'h4F;
            9'h16B:  return 8'h50;
            9'h172:  return 8'h51;
            9'h175:  return 8'h52;
            default: return 8'h00;
        endcase
    endfunction

    assign hid = hid_lookup(ext_flag, rx_byte);

    // Break only releases the key if it is the one currently shown.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            keycode   <= 8'h00;
            key_event <= 1'b0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (frame_err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_strobe) begin
                if (rx_byte == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                    if (hid != 8'h00) begin
                        if (brk_flag) begin
                            if (keycode == hid) begin
                                keycode   <= 8'h00;
                                key_event <= 1'b1;
                            end
                        end else if (keycode != hid) begin
                            keycode   <= hid;
                            key_event <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/ps2_keycode_rx.md
Name: ps2_keycode_rx

Overview:
PS/2 keyboard receiver that produces the 8-bit `keycode` bus consumed by the player controllers.
- Deserialises Set-2 scan-code frames from the keyboard.
- Tracks the E0 (extended) and F0 (break) prefixes.
- Translates the game keys to USB-HID usage codes: A=04, D=07, W=1A, S=16, arrows 4F/50/51/52.
- Holds the most recently pressed, still-held key on `keycode`; 00 when no mapped key is held.
- Sits between the board PS/2 pins and the FireBoy/IceGirl controllers.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 100000: Clk cycles without a falling ps2_clk edge, mid-frame, before the frame is abandoned (2 ms at 50 MHz).

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous, active-low reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- keycode  out  8  HID code of the held key; 00 = none
- key_event  out  1  one-cycle pulse when keycode changes value
- byte_strobe  out  1  one-cycle pulse per accepted frame byte, including prefixes
- rx_byte  out  8  last accepted raw byte, valid with byte_strobe
- frame_err  out  1  one-cycle pulse on stop/parity error or timeout

Behaviour:
- Reset: every output is 0. FSM = IDLE, prefix flags cleared, filter state = 1, shift register = 0. Reset is asynchronous and can assert mid-frame; the first frame after release is received normally.
- Input conditioning:
  - Two-flop synchroniser on each pin.
  - Filtered clock changes only after FILTER_LEN equal samples.
  - A falling edge of the filtered clock samples the synchronised data bit.
- Frame FSM:
  - IDLE → DATA when a 0 start bit is sampled; a sampled 1 keeps the FSM in IDLE.
  - DATA: 8 bits, LSB first, 3-bit counter → PARITY.
  - PARITY: store bit → STOP.
  - STOP: stop=1 and parity good → accept the byte and return to IDLE. Stop=0 → frame_err, discard, return to IDLE.
  - Parity is odd: data ones plus the parity bit must total an odd count.
- Timeout: in any state other than IDLE, a counter reaches TIMEOUT_CYCLES-1 with no falling edge → frame_err, IDLE, prefix flags cleared. The counter resets on each falling edge.
- Byte acceptance:
  - byte_strobe and rx_byte are registered on the cycle after the stop-bit sample.
  - keycode and key_event are registered one cycle later.
- Decode:
  - E0 sets the ext flag; F0 sets the brk flag; neither changes keycode.
  - Any other accepted byte is looked up using the ext flag, then both flags clear.
  - Map, ext=0: 1C→04, 23→07, 1D→1A, 1B→16.
  - Map, ext=1: 74→4F, 6B→50, 72→51, 75→52.
  - Unmapped codes: no keycode change; flags still clear.
- Make of a mapped key: keycode ← HID code. key_event fires only if the value differs, so typematic repeats produce no event.
- Break of a mapped key: keycode ← 00 only if keycode equals that key's HID code; otherwise unchanged.
- frame_err, timeout, or a discarded byte clears both prefix flags and leaves keycode unchanged.
- key_event and byte_strobe never assert in the same cycle for the same byte, because of the one-cycle offset.

Optional Feature:
PS2_RX_PARITY_CHECK_EN
- Defined: bad parity at STOP → frame_err pulse, byte discarded, flags cleared.
- Undefined: parity bit sampled but ignored. Only the stop bit and the timeout raise frame_err.

Test Plan:
- Frame 1C with parity=0, stop=1 → byte_strobe with rx_byte=1C; keycode=04 one cycle later; key_event pulse.
- Sequence 1C, 1C, F0 1C → keycode 04 with one key_event only; 00 after the break with a second key_event.
- Sequence E0 74, 1D, E0 F0 74 → keycode 4F, then 1A. The break of 4F leaves 1A held with no key_event.
- Frame 1C with stop=0 → frame_err pulse, no byte_strobe, keycode unchanged.
- Same frame with parity=1 (bad) → frame_err pulse, no byte_strobe, keycode unchanged when PS2_RX_PARITY_CHECK_EN is defined. Without it, keycode=04.
- Start bit plus 3 data bits, then ps2_clk held high for 100000 cycles → frame_err pulse, FSM back in IDLE; a following F0 1C frame still parses correctly.
- Reset_n low mid-frame → all outputs 0 asynchronously; next full frame 1D → keycode=1A.
